// File: rtl/revaluate_line_store.sv
// Line store for the revaluate controller. It holds one block of input lines loaded from
// upstream, a separate result array written by the datapath, and streams the results back out.
module revaluate_line_store #(
  parameter int DATA_W = 25,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              loaded,
  input  logic [IDX_W-1:0]  line_index,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_start,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  // state | meaning
  // IDLE  | no block resident, waiting for load_start
  // LOAD  | accepting upstream words into the input array
  // READY | block resident, indexed reads and result writes served
  // DRAIN | streaming the result array out in index order

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY, DRAIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  load_cnt;
  logic [CNT_W-1:0]  drain_cnt;
  logic [CNT_W-1:0]  drain_cnt_nxt;
  logic              idx_ok;

  logic [DATA_W-1:0] in_mem  [DEPTH];
  logic [DATA_W-1:0] res_mem [DEPTH];

  assign drain_cnt_nxt = drain_cnt + 1'b1;

  // Only a block smaller than the index space can see an out-of-range line_index.
  generate
    if (DEPTH < (2 ** IDX_W)) begin : g_idx_chk
      assign idx_ok = (line_index < IDX_W'(DEPTH));
    end else begin : g_idx_full
      assign idx_ok = 1'b1;
    end
  endgenerate

  // Storage is deliberately left out of reset; writes are still blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && in_valid && in_ready)
      in_mem[load_cnt[IDX_W-1:0]] <= in_data;
    if (!rst && state == READY && wr_en && idx_ok)
      res_mem[line_index] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load_cnt  <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      loaded    <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD;
            load_cnt <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          if (in_valid && in_ready) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LAST) begin
              state    <= READY;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              loaded   <= 1'b1;
            end
          end
        end

        READY: begin
          if (rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= idx_ok ? in_mem[line_index] : '0;
          end
          // A reload takes priority over a drain request in the same cycle.
          if (load_start) begin
            state    <= LOAD;
            load_cnt <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            loaded   <= 1'b0;
          end else if (drain_start) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            busy      <= 1'b1;
          end
        end

        DRAIN: begin
          if (!out_valid) begin
            out_data  <= res_mem[drain_cnt[IDX_W-1:0]];
            out_valid <= 1'b1;
            out_last  <= (drain_cnt == LAST);
          end else if (out_ready) begin
            if (out_last) begin
              state     <= READY;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              // Present the next word straight away so a held out_ready sees no bubble.
              drain_cnt <= drain_cnt_nxt;
              out_data  <= res_mem[drain_cnt_nxt[IDX_W-1:0]];
              out_last  <= (drain_cnt_nxt == LAST);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/revaluate_line_store.md
Name: revaluate_line_store

Overview:
- Data-side responder for the revaluate controller's read/write-file protocol.
- Loads a block of input lines from an upstream stream on a load request.
- Serves indexed reads to the datapath register stage and accepts indexed result writes.
- On a drain request, streams the results out in index order.

Parameters:
- DATA_W, 25, width of one line word.
- DEPTH, 64, number of lines per block; must be at most 2**IDX_W.
- IDX_W, 6, line index width; matches the controller's line_index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse (controller read_file) to begin loading a block.
- in_data  in  DATA_W  upstream line word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  store accepts in_data this cycle.
- loaded  out  1  a full block is resident and indexed access is enabled.
- line_index  in  IDX_W  index for rd_en and wr_en.
- rd_en  in  1  read request at line_index (controller write_reg).
- rd_data  out  DATA_W  read result, registered.
- rd_valid  out  1  rd_data valid; one cycle after an accepted rd_en.
- wr_en  in  1  result write at line_index (controller write_file).
- wr_data  in  DATA_W  result word.
- drain_start  in  1  one-cycle pulse (controller finish) to begin output streaming.
- out_data  out  DATA_W  result word out.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks the word at index DEPTH-1.
- busy  out  1  high in the LOAD or DRAIN state.

Behaviour:
- Reset (rst=1 at an edge):
  - State becomes IDLE; load and drain counters clear.
  - All outputs go to 0: in_ready, loaded, rd_data, rd_valid, out_data, out_valid, out_last, busy.
  - Storage contents are not cleared.
  - Reset mid-LOAD or mid-DRAIN aborts the operation immediately.
- States: IDLE, LOAD, READY, DRAIN.
- IDLE:
  - load_start=1 -> LOAD; load counter cleared to 0.
  - All other requests are ignored.
- LOAD:
  - in_ready=1 and busy=1.
  - A handshake (in_valid & in_ready) writes in_data to input[cnt] and increments cnt.
  - The handshake that writes index DEPTH-1 causes the transition to READY on the next edge; loaded=1 from that edge.
  - load_start, rd_en, wr_en and drain_start are ignored.
- READY:
  - rd_en:
    - rd_data <= input[line_index], rd_valid <= 1 at the next edge.
    - rd_valid is 0 in any cycle following no accepted rd_en.
    - rd_data holds its last value when rd_valid=0.
  - wr_en:
    - result[line_index] <= wr_data.
    - Input and result arrays are separate, so writes never disturb input words.
  - rd_en and wr_en in the same cycle are both performed, even at the same index.
  - line_index >= DEPTH:
    - The write is dropped.
    - The read returns 0 with rd_valid=1.
  - load_start -> LOAD (reload; loaded drops to 0 at the next edge). Same-cycle rd_en/wr_en are still serviced.
  - drain_start -> DRAIN; drain counter cleared. Same-cycle rd_en/wr_en are still serviced.
  - load_start and drain_start together: load_start wins.
- DRAIN:
  - busy=1; loaded stays 1; rd_en and wr_en are ignored.
  - out_data=result[dcnt] and out_valid=1, registered so the first word appears one cycle after entry.
  - out_last=1 when dcnt==DEPTH-1.
  - Backpressure: while out_ready=0, out_data, out_valid and out_last hold stable.
  - On handshake, dcnt increments and the next word is presented in the following cycle; no bubble when out_ready stays high.
  - The handshake on out_last -> READY; out_valid=0 at the next edge.
  - load_start and drain_start are ignored.
  - Result entries never written since reset drain as X/undefined; the bench compares written indices only.
- Widths:
  - Counters are IDX_W+1 bits, so DEPTH=2**IDX_W terminates without wrap ambiguity.
  - No arithmetic is performed on data.

Test Plan:
- Reset, then load_start and 64 words 0..63 with in_valid held high -> in_ready high for 64 cycles; loaded=1 the cycle after word 63; busy low afterwards.
- Load, then rd_en at line_index=5 -> rd_valid=1 and rd_data=5 exactly one cycle later; back-to-back reads at 6,7 return 6,7 on consecutive cycles.
- wr_en at index 3 (data 0x1ABCDEF) with same-cycle rd_en at index 3 -> rd_data=3 from the input array; after drain, word 3 out=0x1ABCDEF.
- Write result[i]=i+100 for all i, drain with out_ready toggling 1,0,1,0 -> 64 words 100..163 in order, values stable while out_ready=0, out_last only on 163, then READY.
- Insert rst high for one cycle after 20 loaded words -> next edge IDLE, in_ready=0, loaded=0; a new load of 64 words completes normally.
- rd_en/wr_en during LOAD, and drain_start in IDLE -> no rd_valid, no state change; loaded stays 0.
